// File: rtl/eth_tx_byte_packer.sv
// eth_tx_byte_packer: packs an 8-bit frame stream into 32-bit MAC words.
// Tracks frames awaiting MAC status and counts frames and errors.
module eth_tx_byte_packer #(
  parameter int CNT_W        = 16,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             clk_app_i,
  input  logic             rst_clk_app_n,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_sof_i,
  input  logic             s_eof_i,
  output logic             s_ready_o,
  output logic             tx_valid_o,
  output logic [31:0]      tx_data_o,
  output logic             tx_start_o,
  output logic             tx_end_o,
  output logic [1:0]       tx_bytesel_o,
  input  logic             tx_ready_i,
  input  logic [7:0]       tx_status_i,
  input  logic             tx_status_valid_i,
  output logic [7:0]       status_o,
  output logic [CNT_W-1:0] frm_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  localparam logic [2:0] MAX_IF = 3'(MAX_INFLIGHT);

  state_t      state;
  state_t      state_nxt;
  logic [23:0] pack;
  logic [31:0] pack_ext;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic        first;
  logic        first_nxt;
  logic [2:0]  inflight;

  logic        hs;
  logic        stall;
  logic        acc;
  logic        last;
  logic        emit;
  logic        pack_wr;
  logic        frm_err;
  logic        st_err;
  logic        inc;
  logic        dec;
  logic        w_start;
  logic        w_end;
  logic [1:0]  w_bsel;
  logic [31:0] w_data;

  logic [CNT_W:0] err_sum;

  assign hs       = tx_valid_o & tx_ready_i;
  assign stall    = (state == IDLE) & (inflight >= MAX_IF);
  assign s_ready_o = rst_clk_app_n & (~tx_valid_o | tx_ready_i) & ~stall;
  assign acc      = s_valid_i & s_ready_o;
  assign last     = s_eof_i | s_sof_i;
  assign pack_ext = {8'h00, pack};
  assign busy_o   = (state == FRAME) | tx_valid_o | (inflight != 3'd0);

  // Merge stored bytes with the incoming byte; bytes above it stay zero.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(cnt))
        w_data[8*k +: 8] = pack_ext[8*k +: 8];
      else if (k == int'(cnt))
        w_data[8*k +: 8] = s_data_i;
    end
  end

  // State register.
  always_ff @(posedge clk_app_i) begin
    if (!rst_clk_app_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state and per-byte packing decisions.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    pack_wr   = 1'b0;
    frm_err   = 1'b0;
    w_start   = 1'b0;
    w_end     = 1'b0;
    w_bsel    = 2'b00;
    cnt_nxt   = cnt;
    first_nxt = first;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (!s_sof_i) begin
            frm_err = 1'b1;
          end else if (s_eof_i) begin
            emit    = 1'b1;
            w_start = 1'b1;
            w_end   = 1'b1;
            w_bsel  = 2'b01;
          end else begin
            state_nxt = FRAME;
            pack_wr   = 1'b1;
            cnt_nxt   = 2'd1;
            first_nxt = 1'b1;
          end
        end
      end
      FRAME: begin
        if (acc) begin
          frm_err = s_sof_i;
          if (last || cnt == 2'd3) begin
            emit      = 1'b1;
            w_start   = first;
            w_end     = last;
            w_bsel    = last ? cnt + 2'd1 : 2'b00;
            cnt_nxt   = 2'd0;
            first_nxt = 1'b0;
          end else begin
            pack_wr = 1'b1;
            cnt_nxt = cnt + 2'd1;
          end
          if (last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pack register, byte count and first-word flag.
  always_ff @(posedge clk_app_i) begin
    if (!rst_clk_app_n) begin
      pack  <= '0;
      cnt   <= 2'd0;
      first <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      first <= first_nxt;
      if (pack_wr) begin
        case (cnt)
          2'd0:    pack[7:0]   <= s_data_i;
          2'd1:    pack[15:8]  <= s_data_i;
          2'd2:    pack[23:16] <= s_data_i;
          default: pack        <= pack;
        endcase
      end
    end
  end

  // Output word register; held while the MAC stalls.
  always_ff @(posedge clk_app_i) begin
    if (!rst_clk_app_n) begin
      tx_valid_o   <= 1'b0;
      tx_data_o    <= '0;
      tx_start_o   <= 1'b0;
      tx_end_o     <= 1'b0;
      tx_bytesel_o <= 2'b00;
    end else if (emit) begin
      tx_valid_o   <= 1'b1;
      tx_data_o    <= w_data;
      tx_start_o   <= w_start;
      tx_end_o     <= w_end;
      tx_bytesel_o <= w_bsel;
    end else if (hs) begin
      tx_valid_o <= 1'b0;
    end
  end

  assign inc = hs & tx_end_o;
  assign dec = tx_status_valid_i & (inflight != 3'd0);

  // Frames handed to the MAC that still await status.
  always_ff @(posedge clk_app_i) begin
    if (!rst_clk_app_n)
      inflight <= 3'd0;
    else if (inc && !dec)
      inflight <= inflight + 3'd1;
    else if (dec && !inc)
      inflight <= inflight - 3'd1;
  end

  assign st_err  = tx_status_valid_i & tx_status_i[0];
  assign err_sum = {1'b0, err_cnt_o}
                 + (CNT_W+1)'(frm_err)
                 + (CNT_W+1)'(st_err);

  // Status capture and saturating frame/error counters.
  always_ff @(posedge clk_app_i) begin
    if (!rst_clk_app_n) begin
      status_o  <= 8'h00;
      frm_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (tx_status_valid_i) begin
        status_o <= tx_status_i;
        if (frm_cnt_o != {CNT_W{1'b1}})
          frm_cnt_o <= frm_cnt_o + 1'b1;
      end
      err_cnt_o <= err_sum[CNT_W] ? {CNT_W{1'b1}}
                                  : err_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_eth_tx_byte_packer.sv
// tb_eth_tx_byte_packer: directed checks of packing, backpressure,
// in-flight limit, error counting, saturation and reset.
module tb_eth_tx_byte_packer;

  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [1:0]  b;
  } word_t;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_sof;
  logic             s_eof;
  logic             s_ready;
  logic             tx_valid;
  logic [31:0]      tx_data;
  logic             tx_start;
  logic             tx_end;
  logic [1:0]       tx_bsel;
  logic             tx_ready;
  logic [7:0]       tx_status;
  logic             tx_status_valid;
  logic [7:0]       status;
  logic [CNT_W-1:0] frm_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  word_t wq[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  eth_tx_byte_packer #(.CNT_W(CNT_W), .MAX_INFLIGHT(2)) dut (
    .clk_app_i         (clk),
    .rst_clk_app_n     (rst_n),
    .s_valid_i         (s_valid),
    .s_data_i          (s_data),
    .s_sof_i           (s_sof),
    .s_eof_i           (s_eof),
    .s_ready_o         (s_ready),
    .tx_valid_o        (tx_valid),
    .tx_data_o         (tx_data),
    .tx_start_o        (tx_start),
    .tx_end_o          (tx_end),
    .tx_bytesel_o      (tx_bsel),
    .tx_ready_i        (tx_ready),
    .tx_status_i       (tx_status),
    .tx_status_valid_i (tx_status_valid),
    .status_o          (status),
    .frm_cnt_o         (frm_cnt),
    .err_cnt_o         (err_cnt),
    .busy_o            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word that will handshake on the coming edge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready)
      wq.push_back({tx_data, tx_start, tx_end, tx_bsel});
  end

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_sof = 1'b0; s_eof = 1'b0;
    tx_ready = 1'b1; tx_status = 8'h00; tx_status_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d,
                           input logic sof, input logic eof);
    int guard;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
    #1;
    guard = 0;
    while (s_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout byte=%h s_ready stuck at %b", d, s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (tx_valid === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout tx_valid stuck high");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b1; s_data = 8'h11; s_sof = 1'b1; s_eof = 1'b0;
    tx_ready = 1'b1; tx_status = 8'h00; tx_status_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (s_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_s_ready got %b exp 0", s_ready); end
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    n_chk++; if ({tx_data, tx_start, tx_end, tx_bsel} !== 36'h0) begin
      n_fail++;
      $display("FAIL rst_word got %h/%b/%b/%b exp 0",
               tx_data, tx_start, tx_end, tx_bsel); end
    n_chk++; if ({status, frm_cnt, err_cnt} !== '0) begin n_fail++;
      $display("FAIL rst_stats got %h/%0d/%0d exp 0",
               status, frm_cnt, err_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_busy got %b exp 0", busy); end
    s_valid = 1'b0; s_sof = 1'b0;
    rst_n = 1'b1;
    #1;
    n_chk++; if (s_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_release_ready got %b exp 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_words();
    word_t exp [2];
    word_t got;
    do_reset();
    wq.delete();
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    n_chk++; if (tx_valid !== 1'b0) begin n_fail++;
      $display("FAIL w8_early_valid got %b exp 0", tx_valid); end
    send_byte(8'h04, 1'b0, 1'b0);
    n_chk++; if ({tx_valid, tx_data, tx_start, tx_bsel}
                 !== {1'b1, 32'h04030201, 1'b1, 2'b00}) begin n_fail++;
      $display("FAIL w8_latency got v=%b %h s=%b b=%b exp 1 04030201 1 00",
               tx_valid, tx_data, tx_start, tx_bsel); end
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h06, 1'b0, 1'b0);
    send_byte(8'h07, 1'b0, 1'b0);
    send_byte(8'h08, 1'b0, 1'b1);
    drain();
    exp[0] = {32'h04030201, 1'b1, 1'b0, 2'b00};
    exp[1] = {32'h08070605, 1'b0, 1'b1, 2'b00};
    n_chk++; if (wq.size() != 2) begin n_fail++;
      $display("FAIL w8_count got %0d exp 2", wq.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < wq.size()) ? wq[i] : '0;
      n_chk++; if (got !== exp[i]) begin n_fail++;
        $display("FAIL w8_word%0d got %h exp %h", i, got, exp[i]); end
    end
    n_chk++; if (busy !== 1'b1) begin n_fail++;
      $display("FAIL w8_busy_inflight got %b exp 1", busy); end
    tx_status = 8'h00; tx_status_valid = 1'b1;
    @(posedge clk); #1;
    tx_status_valid = 1'b0;
    n_chk++; if ({frm_cnt, err_cnt, busy} !== {3'd1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL w8_status got frm=%0d err=%0d busy=%b exp 1 0 0",
               frm_cnt, err_cnt, busy); end
  endtask

  task automatic test_partial();
    word_t exp [3];
    word_t got;
    do_reset();
    wq.delete();
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    send_byte(8'hDD, 1'b0, 1'b0);
    send_byte(8'hEE, 1'b0, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b1);
    drain();
    exp[0] = {32'hDDCCBBAA, 1'b1, 1'b0, 2'b00};
    exp[1] = {32'h000000EE, 1'b0, 1'b1, 2'b01};
    exp[2] = {32'h0000005A, 1'b1, 1'b1, 2'b01};
    n_chk++; if (wq.size() != 3) begin n_fail++;
      $display("FAIL part_count got %0d exp 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < wq.size()) ? wq[i] : '0;
      n_chk++; if (got !== exp[i]) begin n_fail++;
        $display("FAIL part_word%0d got %h exp %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    word_t exp [2];
    word_t got;
    do_reset();
    wq.delete();
    tx_ready = 1'b0;
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h13, 1'b0, 1'b0);
    send_byte(8'h14, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 8'h15;
    #1;
    for (int c = 0; c < 10; c++) begin
      n_chk++; if (s_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_ready c=%0d got %b exp 0", c, s_ready); end
      n_chk++; if ({tx_valid, tx_data, tx_start, tx_end, tx_bsel}
                   !== {1'b1, 32'h14131211, 1'b1, 1'b0, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got v=%b %h s=%b e=%b b=%b",
                 c, tx_valid, tx_data, tx_start, tx_end, tx_bsel); end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    send_byte(8'h15, 1'b0, 1'b0);
    send_byte(8'h16, 1'b0, 1'b0);
    send_byte(8'h17, 1'b0, 1'b0);
    send_byte(8'h18, 1'b0, 1'b1);
    drain();
    exp[0] = {32'h14131211, 1'b1, 1'b0, 2'b00};
    exp[1] = {32'h18171615, 1'b0, 1'b1, 2'b00};
    n_chk++; if (wq.size() != 2) begin n_fail++;
      $display("FAIL bp_count got %0d exp 2", wq.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < wq.size()) ? wq[i] : '0;
      n_chk++; if (got !== exp[i]) begin n_fail++;
        $display("FAIL bp_word%0d got %h exp %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_inflight();
    word_t exp [3];
    word_t got;
    do_reset();
    wq.delete();
    send_byte(8'h21, 1'b1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h31, 1'b1, 1'b0);
    send_byte(8'h32, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b1; s_data = 8'h41; s_sof = 1'b1; s_eof = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (s_ready !== 1'b0) begin n_fail++;
        $display("FAIL infl_stall c=%0d got %b exp 0", c, s_ready); end
      @(posedge clk); #1;
    end
    tx_status = 8'h01; tx_status_valid = 1'b1;
    @(posedge clk); #1;
    tx_status_valid = 1'b0;
    n_chk++; if (s_ready !== 1'b1) begin n_fail++;
      $display("FAIL infl_release got %b exp 1", s_ready); end
    n_chk++; if ({frm_cnt, err_cnt, status} !== {3'd1, 3'd1, 8'h01}) begin
      n_fail++;
      $display("FAIL infl_status got frm=%0d err=%0d st=%h exp 1 1 01",
               frm_cnt, err_cnt, status); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
    send_byte(8'h42, 1'b0, 1'b1);
    drain();
    exp[0] = {32'h00002221, 1'b1, 1'b1, 2'b10};
    exp[1] = {32'h00003231, 1'b1, 1'b1, 2'b10};
    exp[2] = {32'h00004241, 1'b1, 1'b1, 2'b10};
    n_chk++; if (wq.size() != 3) begin n_fail++;
      $display("FAIL infl_count got %0d exp 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < wq.size()) ? wq[i] : '0;
      n_chk++; if (got !== exp[i]) begin n_fail++;
        $display("FAIL infl_word%0d got %h exp %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_errors();
    do_reset();
    wq.delete();
    send_byte(8'h77, 1'b0, 1'b0);
    n_chk++; if ({err_cnt, tx_valid, busy} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL err_stray got err=%0d v=%b busy=%b exp 1 0 0",
               err_cnt, tx_valid, busy); end
    send_byte(8'h10, 1'b1, 1'b0);
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h30, 1'b1, 1'b0);
    n_chk++; if (err_cnt !== 3'd2) begin n_fail++;
      $display("FAIL err_midsof_cnt got %0d exp 2", err_cnt); end
    n_chk++; if ({tx_valid, tx_data, tx_start, tx_end, tx_bsel}
                 !== {1'b1, 32'h00302010, 1'b1, 1'b1, 2'b11}) begin
      n_fail++;
      $display("FAIL err_midsof_word got v=%b %h s=%b e=%b b=%b",
               tx_valid, tx_data, tx_start, tx_end, tx_bsel); end
    drain();
    tx_status = 8'h01; tx_status_valid = 1'b1;
    send_byte(8'h55, 1'b0, 1'b0);
    tx_status_valid = 1'b0;
    n_chk++; if ({err_cnt, frm_cnt, status, busy}
                 !== {3'd4, 3'd1, 8'h01, 1'b0}) begin n_fail++;
      $display("FAIL err_double got err=%0d frm=%0d st=%h busy=%b",
               err_cnt, frm_cnt, status, busy); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 9; i++)
      send_byte(8'(i), 1'b0, 1'b0);
    n_chk++; if (err_cnt !== 3'd7) begin n_fail++;
      $display("FAIL sat_err got %0d exp 7", err_cnt); end
    tx_status = 8'h80; tx_status_valid = 1'b1;
    @(posedge clk); #1;
    tx_status_valid = 1'b0;
    n_chk++; if ({status, frm_cnt, err_cnt, busy}
                 !== {8'h80, 3'd1, 3'd7, 1'b0}) begin n_fail++;
      $display("FAIL sat_idle_status got st=%h frm=%0d err=%0d busy=%b",
               status, frm_cnt, err_cnt, busy); end
  endtask

  task automatic test_reset_mid();
    word_t got;
    do_reset();
    wq.delete();
    tx_ready = 1'b0;
    send_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b0);
    send_byte(8'hA4, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 8'hA5;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({tx_valid, tx_data, tx_start, tx_end, tx_bsel, busy,
                  s_ready} !== '0) begin n_fail++;
      $display("FAIL rmid_outputs got v=%b %h s=%b e=%b b=%b busy=%b r=%b",
               tx_valid, tx_data, tx_start, tx_end, tx_bsel, busy,
               s_ready); end
    s_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_chk++; if (s_ready !== 1'b1) begin n_fail++;
      $display("FAIL rmid_ready got %b exp 1", s_ready); end
    tx_ready = 1'b1;
    send_byte(8'hC1, 1'b1, 1'b0);
    send_byte(8'hC2, 1'b0, 1'b1);
    drain();
    n_chk++; if (wq.size() != 1) begin n_fail++;
      $display("FAIL rmid_count got %0d exp 1", wq.size()); end
    got = (wq.size() > 0) ? wq[0] : '0;
    n_chk++; if (got !== {32'h0000C2C1, 1'b1, 1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL rmid_word got %h exp %h", got,
               {32'h0000C2C1, 1'b1, 1'b1, 2'b10}); end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_partial();
    test_backpressure();
    test_inflight();
    test_errors();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
